// File: rtl/adc_burst_player_pkg.sv
// Shared definitions for the ADC burst player: FSM state encoding and the
// default gain Q-format.
package adc_burst_player_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
   localparam logic [ST_W-1:0] S_RESTART = 3'd1;
   localparam logic [ST_W-1:0] S_PRE     = 3'd2;
   localparam logic [ST_W-1:0] S_PAY     = 3'd3;
   localparam logic [ST_W-1:0] S_POST    = 3'd4;
   localparam logic [ST_W-1:0] S_DONE    = 3'd5;

   // Gain is unsigned Q(GAIN_W-GAIN_FRAC).GAIN_FRAC; with the defaults a code
   // of 4 is unity, 8 is 2.0 and 10 is 2.5.
   localparam int GAIN_W_DEF    = 8;
   localparam int GAIN_FRAC_DEF = 2;

endpackage

// File: rtl/adc_burst_player_sample_scale.sv
// One rail of the player datapath: optional byte swap, ADC field extraction,
// signed fractional gain, floor shift and saturation to the output width.
// The result is registered and only updates when i_en is high, so the output
// holds its value between strobes.
module adc_burst_player_sample_scale #(
   parameter int DATA_W    = 16,
   parameter int ADC_W     = 12,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_zero,
   input  logic              i_swap,
   input  logic [GAIN_W-1:0] i_gain,
   input  logic [DATA_W-1:0] i_word,
   output logic [DATA_W-1:0] o_sample
);

   // Field is sign-extended and gain zero-extended to the full product width,
   // so the multiply is exact and never overflows.
   localparam int P_W = ADC_W + GAIN_W + 1;
   localparam logic signed [P_W-1:0] SAT_MAX = P_W'((64'd1 << (DATA_W - 1)) - 64'd1);
   localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

   logic        [DATA_W-1:0] word_sw;
   logic signed [ADC_W-1:0]  field;
   logic signed [P_W-1:0]    prod;
   logic signed [P_W-1:0]    scaled;
   logic        [DATA_W-1:0] sat;
   logic                     unused_bits;

   // swap, extract, multiply, floor-shift and clamp
   always_comb begin
      word_sw = i_swap ? {i_word[DATA_W/2-1:0], i_word[DATA_W-1:DATA_W/2]} : i_word;
      field   = word_sw[DATA_W-2 -: ADC_W];
      prod    = $signed({{(P_W-ADC_W){field[ADC_W-1]}}, field})
              * $signed({{(P_W-GAIN_W){1'b0}}, i_gain});
      scaled  = prod >>> GAIN_FRAC;
      if (scaled > SAT_MAX) begin
         sat = SAT_MAX[DATA_W-1:0];
      end else if (scaled < SAT_MIN) begin
         sat = SAT_MIN[DATA_W-1:0];
      end else begin
         sat = scaled[DATA_W-1:0];
      end
   end

   // The sign bit above the field and the sub-LSB bits are not part of the ADC sample.
   assign unused_bits = ^{word_sw[DATA_W-1], word_sw[DATA_W-2-ADC_W:0]};

   // output register, updated once per strobe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sample <= '0;
      end else if (i_en) begin
         o_sample <= i_zero ? '0 : sat;
      end
   end

endmodule

// File: rtl/adc_burst_player.sv
// Burst player: replays stored complex baseband words into the rx ADC input
// port with a restart pulse on the rx start bit, a zero preamble, the scaled
// payload and an idle gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_go; o_rx_start holds its last value
// RESTART | o_rx_start low for RESTART_CYC clocks
// PRE     | one zero-valued strobe per interval, i_pre_zeros of them
// PAY     | one memory strobe per interval from address 0, i_len of them
// POST    | i_post_idle clocks with no strobes
// DONE    | one-cycle o_done, back to IDLE
module adc_burst_player
   import adc_burst_player_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADC_W       = 12,
   parameter int ADDR_W      = 13,
   parameter int CNT_W       = 16,
   parameter int IVL_W       = 8,
   parameter int GAIN_W      = GAIN_W_DEF,
   parameter int GAIN_FRAC   = GAIN_FRAC_DEF,
   parameter int RESTART_CYC = 6
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [2*DATA_W-1:0] i_wr_data,
   input  logic                i_go,
   input  logic                i_abort,
   input  logic [CNT_W-1:0]    i_len,
   input  logic [CNT_W-1:0]    i_pre_zeros,
   input  logic [CNT_W-1:0]    i_post_idle,
   input  logic [IVL_W-1:0]    i_interval,
   input  logic [GAIN_W-1:0]   i_gain,
   input  logic                i_swap,
   output logic [DATA_W-1:0]   o_i,
   output logic [DATA_W-1:0]   o_q,
   output logic                o_vld,
   output logic                o_rx_start,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
   localparam logic [IVL_W-1:0]  IVL_ONE      = IVL_W'(1);
   localparam logic [IVL_W-1:0]  IVL_TWO      = IVL_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  RESTART_LOAD = CNT_W'(RESTART_CYC - 1);

   logic [ST_W-1:0]     state;
   logic [ST_W-1:0]     after_pay, after_pre, after_rst, tgt;
   logic [CNT_W-1:0]    phase_cnt, tgt_cnt;
   logic [IVL_W-1:0]    ivl_cnt, ivl_m1;
   logic [CNT_W-1:0]    len_r, pre_r, post_r;
   logic [GAIN_W-1:0]   gain_r;
   logic                swap_r;
   logic [ADDR_W-1:0]   rd_addr;
   logic [2*DATA_W-1:0] mem [2**ADDR_W];
   logic [2*DATA_W-1:0] rd_data;
   logic                strobe, squash, scale_en;
   logic                s1_vld, s1_zero;

   // Abort only matters while a burst is in flight; in IDLE it merely blocks i_go.
   assign squash   = i_abort && (state != S_IDLE);
   // Interval counter counts down from interval-1, so a strobe is its first cycle.
   assign strobe   = ((state == S_PRE) || (state == S_PAY)) && (ivl_cnt == ivl_m1) && !i_abort;
   assign scale_en = s1_vld && !squash;
   assign o_busy   = (state != S_IDLE);
   assign o_done   = (state == S_DONE);

   // successor state when the current phase ends, skipping empty phases
   always_comb begin
      after_pay = (post_r != '0) ? S_POST : S_DONE;
      after_pre = (len_r != '0) ? S_PAY : after_pay;
      after_rst = (pre_r != '0) ? S_PRE : after_pre;
      case (state)
         S_RESTART: tgt = after_rst;
         S_PRE:     tgt = after_pre;
         S_PAY:     tgt = after_pay;
         S_POST:    tgt = S_DONE;
         default:   tgt = S_IDLE;
      endcase
      case (tgt)
         S_PRE:   tgt_cnt = pre_r - CNT_ONE;
         S_PAY:   tgt_cnt = len_r - CNT_ONE;
         S_POST:  tgt_cnt = post_r - CNT_ONE;
         default: tgt_cnt = '0;
      endcase
   end

   // sequencing FSM, phase/interval down-counters and read address
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_IDLE;
         phase_cnt  <= '0;
         ivl_cnt    <= '0;
         ivl_m1     <= '0;
         len_r      <= '0;
         pre_r      <= '0;
         post_r     <= '0;
         gain_r     <= '0;
         swap_r     <= 1'b0;
         rd_addr    <= '0;
         o_rx_start <= 1'b0;
      end else if (squash) begin
         state      <= S_IDLE;
         o_rx_start <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_go && !i_abort) begin
                  len_r      <= i_len;
                  pre_r      <= i_pre_zeros;
                  post_r     <= i_post_idle;
                  gain_r     <= i_gain;
                  swap_r     <= i_swap;
                  ivl_m1     <= (i_interval < IVL_TWO) ? IVL_ONE : i_interval - IVL_ONE;
                  rd_addr    <= '0;
                  phase_cnt  <= RESTART_LOAD;
                  o_rx_start <= 1'b0;
                  state      <= S_RESTART;
               end
            end
            S_RESTART: begin
               if (phase_cnt == '0) begin
                  o_rx_start <= 1'b1;
                  state      <= tgt;
                  phase_cnt  <= tgt_cnt;
                  ivl_cnt    <= ivl_m1;
               end else begin
                  phase_cnt <= phase_cnt - CNT_ONE;
               end
            end
            S_PRE, S_PAY: begin
               if (strobe && (state == S_PAY)) begin
                  rd_addr <= rd_addr + ADDR_ONE;
               end
               if (ivl_cnt == '0) begin
                  ivl_cnt <= ivl_m1;
                  if (phase_cnt == '0) begin
                     state     <= tgt;
                     phase_cnt <= tgt_cnt;
                  end else begin
                     phase_cnt <= phase_cnt - CNT_ONE;
                  end
               end else begin
                  ivl_cnt <= ivl_cnt - IVL_ONE;
               end
            end
            S_POST: begin
               if (phase_cnt == '0) begin
                  state <= S_DONE;
               end else begin
                  phase_cnt <= phase_cnt - CNT_ONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // sample memory write port; contents survive reset
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   // registered read port; a same-cycle write to this address is seen next time
   always_ff @(posedge i_clk) begin
      if (strobe) begin
         rd_data <= mem[rd_addr];
      end
   end

   // strobe pipeline: read stage, then output stage alongside the scalers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_vld  <= 1'b0;
         s1_zero <= 1'b0;
         o_vld   <= 1'b0;
      end else begin
         s1_vld  <= strobe;
         s1_zero <= (state == S_PRE);
         o_vld   <= scale_en;
      end
   end

   adc_burst_player_sample_scale #(
      .DATA_W    (DATA_W),
      .ADC_W     (ADC_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_sample_scale_i (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (scale_en),
      .i_zero   (s1_zero),
      .i_swap   (swap_r),
      .i_gain   (gain_r),
      .i_word   (rd_data[2*DATA_W-1:DATA_W]),
      .o_sample (o_i)
   );

   adc_burst_player_sample_scale #(
      .DATA_W    (DATA_W),
      .ADC_W     (ADC_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_sample_scale_q (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (scale_en),
      .i_zero   (s1_zero),
      .i_swap   (swap_r),
      .i_gain   (gain_r),
      .i_word   (rd_data[DATA_W-1:0]),
      .o_sample (o_q)
   );

endmodule

// File: tb/tb_adc_burst_player.sv
// Directed bench for adc_burst_player: burst timing, gain/swap/sign/saturation,
// empty bursts, minimum interval, abort, same-address read/write and reset.
module tb_adc_burst_player;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_wr_en = 1'b0;
   logic [12:0] i_wr_addr = '0;
   logic [31:0] i_wr_data = '0;
   logic        i_go = 1'b0;
   logic        i_abort = 1'b0;
   logic [15:0] i_len = '0;
   logic [15:0] i_pre_zeros = '0;
   logic [15:0] i_post_idle = '0;
   logic [7:0]  i_interval = '0;
   logic [7:0]  i_gain = '0;
   logic        i_swap = 1'b0;
   logic [15:0] o_i, o_q;
   logic        o_vld, o_rx_start, o_busy, o_done;

   int checks = 0;
   int errors = 0;
   int nvld, done_cyc, done_cnt, start_low, abort_cyc;
   logic timed_out;
   int vld_cyc [16];
   logic [15:0] vld_i [16];
   logic [15:0] vld_q [16];
   int exp_cyc [6];
   logic [15:0] exp_i [6];
   logic [15:0] exp_q [6];

   adc_burst_player dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_en     (i_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_go        (i_go),
      .i_abort     (i_abort),
      .i_len       (i_len),
      .i_pre_zeros (i_pre_zeros),
      .i_post_idle (i_post_idle),
      .i_interval  (i_interval),
      .i_gain      (i_gain),
      .i_swap      (i_swap),
      .o_i         (o_i),
      .o_q         (o_q),
      .o_vld       (o_vld),
      .o_rx_start  (o_rx_start),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mem_wr(input logic [12:0] a, input logic [15:0] wi, input logic [15:0] wq);
      @(negedge i_clk);
      i_wr_en   = 1'b1;
      i_wr_addr = a;
      i_wr_data = {wi, wq};
      @(negedge i_clk);
      i_wr_en   = 1'b0;
   endtask

   task automatic cfg(input int ivl, input int pre, input int len, input int post,
                      input int gain, input logic swap);
      i_interval  = 8'(ivl);
      i_pre_zeros = 16'(pre);
      i_len       = 16'(len);
      i_post_idle = 16'(post);
      i_gain      = 8'(gain);
      i_swap      = swap;
   endtask

   // Pulses i_go, then samples every cycle (cycle 1 = first clock after the
   // go edge) until o_busy drops. Optionally writes memory during cycle wr_at.
   task automatic run_burst(input int budget, input int wr_at,
                            input logic [12:0] wa, input logic [31:0] wd);
      nvld = 0; done_cyc = -1; done_cnt = 0; start_low = 0; timed_out = 1'b1;
      @(negedge i_clk);
      i_go = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         if (o_vld === 1'b1) begin
            if (nvld < 16) begin
               vld_cyc[nvld] = k;
               vld_i[nvld]   = o_i;
               vld_q[nvld]   = o_q;
            end
            nvld++;
         end
         if (o_rx_start === 1'b0) start_low++;
         if (o_done === 1'b1) begin
            done_cyc = k;
            done_cnt++;
         end
         if (o_busy === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
         i_wr_en   = (k == wr_at);
         i_wr_addr = wa;
         i_wr_data = wd;
         @(negedge i_clk);
      end
      i_wr_en = 1'b0;
      chk("burst_timeout", {31'd0, timed_out}, 32'd0);
   endtask

   initial begin
      // reset values
      #1 i_rst = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      chk("rst_o_i", {16'd0, o_i}, 32'd0);
      chk("rst_o_q", {16'd0, o_q}, 32'd0);
      chk("rst_vld", {31'd0, o_vld}, 32'd0);
      chk("rst_rx_start", {31'd0, o_rx_start}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      i_rst = 1'b0;

      mem_wr(13'd0, 16'h3412, 16'hFFF8);
      mem_wr(13'd1, 16'h3FF8, 16'h4000);
      mem_wr(13'd2, 16'h4000, 16'h3FF8);
      mem_wr(13'd3, 16'h0008, 16'h0010);

      // timing: interval 8, 2 zeros, 4 payload, 5 idle, gain 2.0
      cfg(8, 2, 4, 5, 8, 1'b0);
      run_burst(200, 0, '0, '0);
      exp_cyc = '{9, 17, 25, 33, 41, 49};
      exp_i   = '{16'h0000, 16'h0000, 16'h0D04, 16'h0FFE, 16'hF000, 16'h0002};
      exp_q   = '{16'h0000, 16'h0000, 16'hFFFE, 16'hF000, 16'h0FFE, 16'h0004};
      chk("t1_nvld", nvld, 6);
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("t1_cyc%0d", j), vld_cyc[j], exp_cyc[j]);
         chk($sformatf("t1_i%0d", j), {16'd0, vld_i[j]}, {16'd0, exp_i[j]});
         chk($sformatf("t1_q%0d", j), {16'd0, vld_q[j]}, {16'd0, exp_q[j]});
      end
      chk("t1_done_cyc", done_cyc, 60);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_start_low", start_low, 6);
      chk("t1_rx_start_end", {31'd0, o_rx_start}, 32'd1);

      // swap with gain 2.0 and 2.5
      cfg(2, 0, 1, 0, 8, 1'b1);
      run_burst(60, 0, '0, '0);
      chk("t2_nvld", nvld, 1);
      chk("t2_cyc", vld_cyc[0], 9);
      chk("t2_done_cyc", done_cyc, 9);
      chk("t2_i", {16'd0, vld_i[0]}, 32'h048C);
      chk("t2_q", {16'd0, vld_q[0]}, 32'hFE3E);
      cfg(2, 0, 1, 0, 10, 1'b1);
      run_burst(60, 0, '0, '0);
      chk("t3_i", {16'd0, vld_i[0]}, 32'h05AF);
      chk("t3_q", {16'd0, vld_q[0]}, 32'hFDCD);

      // negative field, gain 4.0
      cfg(2, 0, 1, 0, 16, 1'b0);
      run_burst(60, 0, '0, '0);
      chk("t4_i", {16'd0, vld_i[0]}, 32'h1A08);
      chk("t4_q", {16'd0, vld_q[0]}, 32'hFFFC);

      // saturation at max gain, interval 1 treated as 2
      cfg(1, 0, 2, 0, 255, 1'b0);
      run_burst(60, 0, '0, '0);
      chk("t5_nvld", nvld, 2);
      chk("t5_cyc0", vld_cyc[0], 9);
      chk("t5_cyc1", vld_cyc[1], 11);
      chk("t5_i0", {16'd0, vld_i[0]}, 32'h7FFF);
      chk("t5_q0", {16'd0, vld_q[0]}, 32'hFFC0);
      chk("t5_i1", {16'd0, vld_i[1]}, 32'h7FFF);
      chk("t5_q1", {16'd0, vld_q[1]}, 32'h8000);
      chk("t5_done_cyc", done_cyc, 11);

      // empty preamble and payload
      cfg(8, 0, 0, 3, 8, 1'b0);
      run_burst(60, 0, '0, '0);
      chk("t6_nvld", nvld, 0);
      chk("t6_done_cyc", done_cyc, 10);
      chk("t6_start_low", start_low, 6);

      // abort mid-payload after three samples
      cfg(4, 0, 8, 2, 8, 1'b0);
      nvld = 0; abort_cyc = -1; timed_out = 1'b1;
      @(negedge i_clk);
      i_go = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (o_vld === 1'b1) nvld++;
         if (nvld == 3) begin
            timed_out = 1'b0;
            abort_cyc = k;
            break;
         end
         @(negedge i_clk);
      end
      chk("t7_reach3", {31'd0, timed_out}, 32'd0);
      chk("t7_vld3_cyc", abort_cyc, 17);
      i_abort = 1'b1;
      @(negedge i_clk);
      i_abort = 1'b0;
      chk("t7_busy", {31'd0, o_busy}, 32'd0);
      chk("t7_rx_start", {31'd0, o_rx_start}, 32'd1);
      nvld = 0; done_cnt = 0;
      repeat (20) begin
         @(negedge i_clk);
         if (o_vld === 1'b1) nvld++;
         if (o_done === 1'b1) done_cnt++;
      end
      chk("t7_vld_after", nvld, 0);
      chk("t7_done_after", done_cnt, 0);

      // go together with abort in IDLE is ignored
      @(negedge i_clk);
      i_go = 1'b1;
      i_abort = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      i_abort = 1'b0;
      chk("t7b_busy", {31'd0, o_busy}, 32'd0);
      chk("t7b_rx_start", {31'd0, o_rx_start}, 32'd1);

      // next burst restarts at address 0
      cfg(2, 0, 1, 0, 8, 1'b0);
      run_burst(60, 0, '0, '0);
      chk("t8_i", {16'd0, vld_i[0]}, 32'h0D04);
      chk("t8_q", {16'd0, vld_q[0]}, 32'hFFFE);

      // write to address 0 in the read cycle: old data, then new data
      run_burst(60, 7, 13'd0, {16'h0010, 16'h0008});
      chk("t9_old_i", {16'd0, vld_i[0]}, 32'h0D04);
      chk("t9_old_q", {16'd0, vld_q[0]}, 32'hFFFE);
      run_burst(60, 0, '0, '0);
      chk("t9_new_i", {16'd0, vld_i[0]}, 32'h0004);
      chk("t9_new_q", {16'd0, vld_q[0]}, 32'h0002);

      // asynchronous reset in the preamble
      cfg(8, 4, 2, 0, 8, 1'b0);
      @(negedge i_clk);
      i_go = 1'b1;
      @(negedge i_clk);
      i_go = 1'b0;
      repeat (7) @(negedge i_clk);
      chk("t10_pre_busy", {31'd0, o_busy}, 32'd1);
      chk("t10_pre_rx_start", {31'd0, o_rx_start}, 32'd1);
      chk("t10_pre_o_i", {16'd0, o_i}, 32'h0004);
      #2 i_rst = 1'b1;
      #1;
      chk("t10_o_i", {16'd0, o_i}, 32'd0);
      chk("t10_o_q", {16'd0, o_q}, 32'd0);
      chk("t10_vld", {31'd0, o_vld}, 32'd0);
      chk("t10_rx_start", {31'd0, o_rx_start}, 32'd0);
      chk("t10_busy", {31'd0, o_busy}, 32'd0);
      chk("t10_done", {31'd0, o_done}, 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // memory survives reset
      cfg(2, 0, 1, 0, 8, 1'b0);
      run_burst(60, 0, '0, '0);
      chk("t11_nvld", nvld, 1);
      chk("t11_i", {16'd0, vld_i[0]}, 32'h0004);
      chk("t11_q", {16'd0, vld_q[0]}, 32'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_burst_player.md
Name: adc_burst_player

Overview:
- Synthesizable, parametrised successor to the rx bench stimulus loop.
- Plays stored complex baseband bursts into the rx input port (i_fromADC_i/q/vld) and drives the rx `start` control bit.
- Sequence per burst: restart pulse on `start`, zero-padding preamble, payload with byte-swap, ADC-width extraction and programmable fractional gain, then idle gap.
- Used for on-board loopback and regression without RF.

Parameters:
- DATA_W, 16: stored word and output sample width.
- ADC_W, 12: extracted ADC field width; field is word bits [DATA_W-2 -: ADC_W].
- ADDR_W, 13: sample memory depth is 2^ADDR_W complex words.
- CNT_W, 16: width of length, pad and gap counters.
- IVL_W, 8: width of the sample-interval field.
- GAIN_W, 8: unsigned gain width.
- GAIN_FRAC, 2: fractional bits of gain (8 = 2.0, 10 = 2.5).
- RESTART_CYC, 6: clocks `o_rx_start` is held low before each burst.

Ports:
- i_clk  in  1  player clock (rx ADC clock domain)
- i_rst  in  1  reset, asynchronous, active-high
- i_wr_en  in  1  sample memory write strobe
- i_wr_addr  in  ADDR_W  sample memory write address
- i_wr_data  in  2*DATA_W  {I,Q} raw words
- i_go  in  1  one-cycle pulse, starts a burst
- i_abort  in  1  terminates the burst
- i_len  in  CNT_W  payload sample count
- i_pre_zeros  in  CNT_W  zero-valued valid samples before the payload
- i_post_idle  in  CNT_W  clocks with vld low after the payload
- i_interval  in  IVL_W  clocks per sample; values below 2 are treated as 2
- i_gain  in  GAIN_W  unsigned gain in Q(GAIN_W-GAIN_FRAC).GAIN_FRAC
- i_swap  in  1  swap bytes of each stored word
- o_i, o_q  out  DATA_W  sample to rx
- o_vld  out  1  sample strobe
- o_rx_start  out  1  rx ctrl start bit
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: o_i = o_q = 0, o_vld = 0, o_rx_start = 0, o_busy = 0, o_done = 0; FSM enters IDLE.
- Reset is async and can occur mid-burst. The memory contents are not cleared by reset.
- Configuration (i_len, i_pre_zeros, i_post_idle, i_interval, i_gain, i_swap) is latched on the i_go cycle and held for the whole burst.

FSM:
- IDLE: on i_go go to RESTART. i_go is ignored in all other states.
- RESTART: o_rx_start = 0 for RESTART_CYC clocks, then set to 1 and go to PRE.
- PRE: emit i_pre_zeros strobes with data 0, then go to PAY. Skip this state if the count is 0.
- PAY: emit i_len strobes, reading memory from address 0 upward. The address wraps modulo 2^ADDR_W. Skip this state if i_len is 0.
- POST: wait i_post_idle clocks with o_vld = 0, then go to DONE. Skip this state if the count is 0.
- DONE: pulse o_done for one cycle, go to IDLE. o_rx_start stays 1.

Strobe timing:
- In PRE and PAY an interval counter runs 0..interval-1; a strobe fires at count 0, i.e. on the first cycle of each state.
- Strobe-to-o_vld latency is 2 clocks: memory read, then output register.
- o_vld is high for exactly one cycle per strobe.
- o_i/o_q hold their value between strobes.

Datapath, per rail:
- If i_swap, exchange the two bytes of the word.
- Take field f = word[DATA_W-2 -: ADC_W] as signed.
- p = f * gain, signed, full precision.
- Arithmetic shift p right by GAIN_FRAC, truncating toward -inf.
- Saturate to the signed DATA_W range.

Boundary conditions:
- i_abort in any non-IDLE state: go to IDLE next clock. Pipeline o_vld is squashed, o_done is not pulsed, o_rx_start is forced to 1.
- Write and read of the same address in the same cycle: the read returns the old data.
- i_go together with i_abort in IDLE: the abort wins.

Decomposition:
- Shared package: FSM state encoding (IDLE, RESTART, PRE, PAY, POST, DONE) and the gain Q-format constants.
- Natural sub-module: `sample_scale`, the swap/extract/multiply/saturate stage. Instantiate it twice, once for I and once for Q, with a registered output.
- Memory: inferred simple dual-port RAM inside the top module.

Test Plan:
- Timing: interval = 8, pre = 2, len = 4, post = 5. Expect o_rx_start low for 6 clocks after i_go. Then 6 o_vld pulses spaced exactly 8 clocks apart; the first 2 carry 0. o_done fires 5 clocks after the last strobe plus pipeline.
- Gain and swap: word 0x3412, swap = 1 → field +582. gain = 8 → o_i = 1164; gain = 10 → o_i = 1455.
- Sign: word 0xFFF8, swap = 0 → field −1. gain = 16 → o_q = −4 (0xFFFC).
- Saturation: field +2047, gain = 255 → o_i = 32767. Field −2048, gain = 255 → o_i = −32768.
- Abort: i_abort mid-PAY after 3 strobes → o_busy low the next clock, no further o_vld, no o_done. A new i_go then restarts reading from address 0.
- Edges: i_len = 0 and i_pre_zeros = 0 → no o_vld, o_done after RESTART plus post. i_interval = 1 → strobes every 2 clocks. Async i_rst mid-PRE → all outputs 0 immediately.
